// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC sample controller.
package tdc_pkg;

  localparam int TDC_DEF_CNT_WIDTH  = 16;
  localparam int TDC_DEF_CODE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } tdc_ctrl_state_t;

  // States in which a run is in flight and returned results are counted.
  function automatic logic is_run_state(input tdc_ctrl_state_t s);
    return (s == ST_ISSUE) || (s == ST_GAP) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/tdc_down_counter.sv
// Loadable down counter that stops at zero; used for GAP spacing and DRAIN timeout.
module tdc_down_counter #(
  parameter int C_WIDTH = 16
) (
  input  logic               clk_capt,
  input  logic               reset,
  input  logic               load,
  input  logic [C_WIDTH-1:0] load_value,
  input  logic               dec,
  output logic               zero
);

  logic [C_WIDTH-1:0] count_reg;

  always_ff @(posedge clk_capt or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/tdc_sample_ctrl.sv
// Run controller: issues a configured number of pulse commands on an AV-ST
// source, spaced by an idle interval, then waits for the matching TDC results.
module tdc_sample_ctrl
  import tdc_pkg::*;
#(
  parameter int C_CNT_WIDTH  = TDC_DEF_CNT_WIDTH,
  parameter int C_CODE_WIDTH = TDC_DEF_CODE_WIDTH
) (
  input  logic                    clk_capt,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [C_CNT_WIDTH-1:0]  cfg_num_samples,
  input  logic [C_CNT_WIDTH-1:0]  cfg_interval,
  input  logic [C_CNT_WIDTH-1:0]  cfg_timeout,
  input  logic [C_CODE_WIDTH-1:0] cfg_pulse_code,
  output logic [C_CODE_WIDTH-1:0] M_AVST_DATA,
  output logic                    M_AVST_VALID,
  input  logic                    M_AVST_READY,
  input  logic                    result_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [C_CNT_WIDTH-1:0]  issued_count,
  output logic [C_CNT_WIDTH-1:0]  result_count
);

  // Reset asserts immediately but releases only after two clk_capt edges.
  logic [1:0] rst_sync_reg;
  logic       rst_int;

  always_ff @(posedge clk_capt or posedge reset) begin
    if (reset) begin
      rst_sync_reg <= 2'b11;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_reg[1];

  tdc_ctrl_state_t         state_reg;
  logic [C_CNT_WIDTH-1:0]  num_reg;
  logic [C_CNT_WIDTH-1:0]  interval_reg;
  logic [C_CNT_WIDTH-1:0]  timeout_reg;
  logic [C_CODE_WIDTH-1:0] data_reg;
  logic                    valid_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    timeout_err_reg;
  logic [C_CNT_WIDTH-1:0]  issued_reg;
  logic [C_CNT_WIDTH-1:0]  result_reg;

  logic                    run_abort;
  logic                    handshake;
  logic [C_CNT_WIDTH-1:0]  issued_inc;
  logic                    last_pulse;
  logic                    result_hit;
  logic [C_CNT_WIDTH-1:0]  result_next;
  logic                    results_complete;
  logic                    gap_load;
  logic                    drain_load;
  logic                    gap_zero;
  logic                    drain_zero;

  assign run_abort        = abort && (state_reg != ST_IDLE);
  assign handshake        = (state_reg == ST_ISSUE) && valid_reg && M_AVST_READY;
  assign issued_inc       = issued_reg + 1'b1;
  assign last_pulse       = (issued_inc == num_reg);
  // Result count saturates at the requested sample count.
  assign result_hit       = result_valid && is_run_state(state_reg) && (result_reg != num_reg);
  assign result_next      = result_hit ? (result_reg + 1'b1) : result_reg;
  assign results_complete = (result_next == num_reg);
  assign gap_load         = !run_abort && handshake && !last_pulse && (interval_reg != '0);
  assign drain_load       = !run_abort && handshake && last_pulse;

  // Loaded with N-1 so the zero flag marks the Nth cycle of the wait.
  tdc_down_counter #(.C_WIDTH(C_CNT_WIDTH)) u_gap_cnt (
    .clk_capt   (clk_capt),
    .reset      (rst_int),
    .load       (gap_load),
    .load_value (interval_reg - 1'b1),
    .dec        (state_reg == ST_GAP),
    .zero       (gap_zero)
  );

  tdc_down_counter #(.C_WIDTH(C_CNT_WIDTH)) u_drain_cnt (
    .clk_capt   (clk_capt),
    .reset      (rst_int),
    .load       (drain_load),
    .load_value (timeout_reg - 1'b1),
    .dec        (state_reg == ST_DRAIN),
    .zero       (drain_zero)
  );

  always_ff @(posedge clk_capt or posedge rst_int) begin
    if (rst_int) begin
      state_reg       <= ST_IDLE;
      num_reg         <= '0;
      interval_reg    <= '0;
      timeout_reg     <= '0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      issued_reg      <= '0;
      result_reg      <= '0;
    end else if (run_abort) begin
      state_reg <= ST_IDLE;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            num_reg         <= cfg_num_samples;
            interval_reg    <= cfg_interval;
            timeout_reg     <= cfg_timeout;
            data_reg        <= cfg_pulse_code;
            issued_reg      <= '0;
            result_reg      <= '0;
            timeout_err_reg <= 1'b0;
            if (cfg_num_samples == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_ISSUE;
              valid_reg <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          result_reg <= result_next;
          if (handshake) begin
            issued_reg <= issued_inc;
            if (last_pulse) begin
              state_reg <= ST_DRAIN;
              valid_reg <= 1'b0;
            end else if (interval_reg != '0) begin
              state_reg <= ST_GAP;
              valid_reg <= 1'b0;
            end
          end
        end

        ST_GAP: begin
          result_reg <= result_next;
          if (gap_zero) begin
            state_reg <= ST_ISSUE;
            valid_reg <= 1'b1;
          end
        end

        ST_DRAIN: begin
          result_reg <= result_next;
          if (results_complete) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if ((timeout_reg != '0) && drain_zero) begin
            state_reg       <= ST_DONE;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b1;
            timeout_err_reg <= 1'b1;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign M_AVST_DATA  = data_reg;
  assign M_AVST_VALID = valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign timeout_err  = timeout_err_reg;
  assign issued_count = issued_reg;
  assign result_count = result_reg;

endmodule

// File: doc/tdc_sample_ctrl.md
TDC_SAMPLE_CTRL -- requirements
Module: tdc_sample_ctrl

Interface
REQ-001 Parameter C_CNT_WIDTH, default 16: width of sample, interval and timeout counters.
REQ-002 Parameter C_CODE_WIDTH, default 8: width of the pulse code sent to the pulse generator / carry_top AV-ST input.
REQ-003 Port clk_capt, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle request to begin a run.
REQ-006 Port abort, input, 1: terminate the run immediately.
REQ-007 Port cfg_num_samples, input, C_CNT_WIDTH: number of pulses to issue.
REQ-008 Port cfg_interval, input, C_CNT_WIDTH: idle cycles between accepted pulses.
REQ-009 Port cfg_timeout, input, C_CNT_WIDTH: maximum DRAIN cycles; 0 disables the timeout.
REQ-010 Port cfg_pulse_code, input, C_CODE_WIDTH: code driven on M_AVST_DATA.
REQ-011 Port M_AVST_DATA, output, C_CODE_WIDTH; M_AVST_VALID, output, 1; M_AVST_READY, input, 1: pulse command stream.
REQ-012 Port result_valid, input, 1: one-cycle strobe, one per TDC sample returned.
REQ-013 Ports busy, output, 1; done, output, 1; timeout_err, output, 1; issued_count and result_count, outputs, C_CNT_WIDTH each.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, GAP, DRAIN, DONE.
REQ-015 IDLE + start: latch all cfg_* inputs, clear both counts and timeout_err; go to DONE if latched num_samples==0, else ISSUE.
REQ-016 start outside IDLE SHALL be ignored; cfg_* changes after latching SHALL have no effect on the run.
REQ-017 ISSUE: M_AVST_VALID=1 and M_AVST_DATA=latched code, both held stable until M_AVST_VALID&M_AVST_READY.
REQ-018 On handshake, issued_count SHALL increment; if the new value equals num_samples go to DRAIN; else go to GAP when interval>0, or stay in ISSUE when interval==0 (back-to-back pulses, one per cycle while READY is high).
REQ-019 GAP: M_AVST_VALID=0 for exactly latched interval cycles, then ISSUE.
REQ-020 result_valid SHALL increment result_count in ISSUE, GAP and DRAIN only; result_count saturates at num_samples; result_valid in IDLE/DONE is ignored.
REQ-021 DRAIN: go to DONE when result_count==num_samples (including a strobe in the current cycle); if timeout>0 and timeout cycles elapse first, set timeout_err and go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; timeout_err holds until the next accepted start.
REQ-023 busy=1 in ISSUE, GAP, DRAIN; 0 in IDLE, DONE.
REQ-024 abort in any non-IDLE state: IDLE on the next edge, M_AVST_VALID=0 that edge, no done pulse, counts retained; abort has priority over start, handshake and result_valid in the same cycle.
REQ-025 M_AVST_VALID SHALL be a registered output; latency from start to first M_AVST_VALID is exactly 1 cycle.
REQ-026 Counters SHALL never wrap; num_samples max is 2^C_CNT_WIDTH-1.

Reset
REQ-027 reset SHALL force IDLE asynchronously; M_AVST_VALID, busy, done, timeout_err, issued_count, result_count = 0; M_AVST_DATA = 0.
REQ-028 reset asserted mid-run SHALL discard the run without a done pulse; deassertion SHALL be synchronised to clk_capt before the FSM leaves IDLE.

Structure
REQ-029 Package tdc_pkg SHALL hold the FSM state enum (tdc_ctrl_state_t) and the C_CNT_WIDTH / C_CODE_WIDTH defaults.
REQ-030 One sub-module, tdc_down_counter (load, decrement, zero flag), SHALL be instantiated twice: once for the GAP interval and once for the DRAIN timeout.

Verification
REQ-031 num=4, interval=0, READY=1: VALID high for 4 consecutive cycles starting 1 cycle after start; 4 result strobes -> done 1 cycle; issued=result=4.
REQ-032 num=3, interval=2, READY toggling: exactly 2 VALID-low cycles after each handshake; DATA stable while VALID&!READY.
REQ-033 num=0: start -> DONE -> IDLE; done pulses once; VALID never asserted.
REQ-034 num=5, timeout=10, only 3 results returned: timeout_err=1 and done exactly 10 DRAIN cycles after DRAIN entry; result_count=3.
REQ-035 abort in the same cycle as a handshake while in ISSUE: next cycle IDLE, VALID=0, no done; a new start is accepted afterwards.
REQ-036 reset asserted in GAP: all outputs 0 immediately; start while busy: ignored.
